hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Producer-side companion to the operand forwarding network, sitting in the decode stage.
//  - Records each issued instruction's destination register and how many cycles remain
//    until its result reaches the forwarding paths.
//  - Stalls decode when a source operand names a register that forwarding cannot yet supply
//    (e.g. load-use), and inserts a bubble into EX.
// PARAMETERS
//  NREGS   32  number of architectural registers (register 0 hard-wired zero)
//  REGW    5   register index width, log2(NREGS)
//  CNTW    2   per-register countdown width
//  MAXLAT  3   largest accepted latency; larger issue_lat saturates to MAXLAT (<= 2**CNTW-1)
// PORTS
//  clk          in   1     rising-edge clock
//  reset_n      in   1     asynchronous active-low reset
//  issue_valid  in   1     decode holds a valid instruction this cycle
//  issue_wr     in   1     that instruction writes a register
//  issue_rd     in   REGW  its destination register
//  issue_lat    in   CNTW  cycles until its result is forwardable (0 = ALU, 1 = load, ...)
//  Rs           in   REGW  source register A of the decode instruction
//  Rt           in   REGW  source register B of the decode instruction
//  readRs       in   1     instruction actually reads Rs
//  readRt       in   1     instruction actually reads Rt
//  flush        in   1     pipeline flush (branch taken / exception)
//  stall        out  1     hold PC and IF/ID this cycle
//  bubble       out  1     force a NOP into ID/EX this cycle
//  stall_count  out  32    total stall cycles (see CONFIGURATION)
// BEHAVIOUR
//  - State: cnt[r] of CNTW bits for r = 1..NREGS-1; r0 has no counter and always reads 0.
//  - Reset (asynchronous, reset_n=0): all cnt = 0, so stall = 0, bubble = 0, stall_count = 0.
//    Reset asserted mid-stall drops stall in the same cycle; there is no recovery state.
//  - stall is combinational from state:
//      stall = valid & ((readRs & Rs!=0 & cnt[Rs]!=0) | (readRt & Rt!=0 & cnt[Rt]!=0)).
//    bubble == stall.
//  - Issue accept: issue_valid & issue_wr & issue_rd!=0 & !stall & !flush.
//    The accepting edge writes cnt[issue_rd] = min(issue_lat, MAXLAT).
//    issue_lat = 0 writes 0, so that instruction causes no stall.
//  - Countdown: on every edge, every nonzero cnt not written by issue decrements by 1,
//    saturating at 0. Stall length is therefore exactly the remaining count.
//  - Simultaneous events:
//    - Issue to a register whose cnt is also decrementing: the issue write wins.
//    - A stalled instruction never issues; it re-presents unchanged next cycle.
//    - Self-dependence (Rs == issue_rd) is evaluated against the pre-issue cnt.
//  - flush: the next edge clears every cnt to 0, and any issue in that cycle is discarded.
//    stall is still evaluated on the current state during the flush cycle.
//  - Latency: a write accepted at edge N with lat L makes stall=1 for a dependent reader
//    during cycles N..N+L-1, and stall=0 from cycle N+L.
//  - Flow-through: no other pipeline registers; outputs valid in the same cycle as inputs.
// CONFIGURATION
//  HAZARD_STATS_EN defined:
//    - stall_count is a 32-bit register, incremented on each edge where stall=1.
//    - It wraps from 0xFFFFFFFF to 0, is unaffected by flush, and is cleared by reset_n.
//  HAZARD_STATS_EN undefined: no counter is built; stall_count is constant 0.
// TESTING
//  1 Issue rd=5, lat=1; next instruction has Rs=5, readRs=1
//    -> stall=1 and bubble=1 for exactly 1 cycle, then 0.
//  2 Issue rd=5, lat=0; next instruction reads Rs=5 -> stall stays 0.
//  3 Issue rd=7, lat=3; reader has Rt=7, readRt=0 -> no stall.
//    Repeat with readRt=1 -> stall=1 for 3 cycles.
//  4 Issue rd=0, lat=2; next instruction reads Rs=0 and Rt=0 -> stall stays 0, no state written.
//  5 Issue rd=9, lat=3; one cycle later assert flush -> stall=0 on the following cycle.
//    Reader of r9 is not stalled afterwards.
//  6 Hold reset_n=0 for 1 cycle while stall=1, with HAZARD_STATS_EN defined and stall_count=4
//    -> stall=0 and stall_count=0 immediately.
//    Scenario 1 afterwards -> stall_count=1.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: per-register countdown until a result is forwardable.
// Define HAZARD_STATS_EN to build the 32-bit stall cycle counter on stall_count.
module hazard_scoreboard #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned REGW   = 5,
  parameter int unsigned CNTW   = 2,
  parameter int unsigned MAXLAT = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            issue_valid,
  input  logic            issue_wr,
  input  logic [REGW-1:0] issue_rd,
  input  logic [CNTW-1:0] issue_lat,
  input  logic [REGW-1:0] Rs,
  input  logic [REGW-1:0] Rt,
  input  logic            readRs,
  input  logic            readRt,
  input  logic            flush,
  output logic            stall,
  output logic            bubble,
  output logic [31:0]     stall_count
);

  localparam logic [CNTW-1:0] MaxLat = CNTW'(MAXLAT);

  logic [NREGS-1:0][CNTW-1:0] cnt_q, cnt_d;
  logic                       rs_busy, rt_busy, accept;
  logic [CNTW-1:0]            lat_sat;

  always_comb begin
    rs_busy = readRs && (Rs != '0) && (cnt_q[Rs] != '0);
    rt_busy = readRt && (Rt != '0) && (cnt_q[Rt] != '0);
    stall   = issue_valid && (rs_busy || rt_busy);
    bubble  = stall;
    accept  = issue_valid && issue_wr && (issue_rd != '0) && !stall && !flush;
    lat_sat = (issue_lat > MaxLat) ? MaxLat : issue_lat;
  end

  // Issue write overrides the countdown; flush overrides everything.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 1; r < int'(NREGS); r++) begin
      if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CNTW'(1);
      end
    end
    cnt_d[0] = '0;
    if (accept) begin
      cnt_d[issue_rd] = lat_sat;
    end
    if (flush) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q + {31'd0, stall};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule
